// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the RGB LCD panel. Free-running h/v counters
// are decoded into sync/active flags, which travel down a fixed three-stage
// pipeline so that the panel sync, data enable and colour leave together.
// Pixel coordinates are requested one stage early so the renderer's
// registered lookup lines up with the data-enable stage.
module lcd_timing_gen #(
    parameter int H_SYNC  = 41,
    parameter int H_BACK  = 2,
    parameter int H_DISP  = 480,
    parameter int H_FRONT = 2,
    parameter int V_SYNC  = 10,
    parameter int V_BACK  = 2,
    parameter int V_DISP  = 272,
    parameter int V_FRONT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        data_req,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        lcd_bl,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [10:0] H_SYNC_C    = 11'(H_SYNC);
    localparam logic [10:0] H_ACT_BEG_C = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_END_C = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] H_LAST_C    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_SYNC_C    = 11'(V_SYNC);
    localparam logic [10:0] V_ACT_BEG_C = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_ACT_END_C = 11'(V_SYNC + V_BACK + V_DISP);
    localparam logic [10:0] V_LAST_C    = 11'(V_TOTAL - 1);

    // Stage 0: raster position counters
    logic [10:0] h_cnt_r;
    logic [10:0] v_cnt_r;

    // Stage 0 decode
    logic        hs0_s;
    logic        vs0_s;
    logic        act0_s;
    logic        fs0_s;
    logic [10:0] xpos0_s;
    logic [10:0] ypos0_s;

    // Stage 1 and stage 2 delay registers
    logic hs1_r, vs1_r, act1_r, fs1_r;
    logic hs2_r, vs2_r, act2_r, fs2_r;

    // Horizontal counter wraps every line; vertical advances only on that wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= 11'd0;
            v_cnt_r <= 11'd0;
        end else if (h_cnt_r == H_LAST_C) begin
            h_cnt_r <= 11'd0;
            if (v_cnt_r == V_LAST_C) begin
                v_cnt_r <= 11'd0;
            end else begin
                v_cnt_r <= v_cnt_r + 11'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 11'd1;
        end
    end

    // Decode the current raster position into sync, active and coordinates
    always_comb begin
        hs0_s   = (h_cnt_r < H_SYNC_C);
        vs0_s   = (v_cnt_r < V_SYNC_C);
        act0_s  = (h_cnt_r >= H_ACT_BEG_C) && (h_cnt_r < H_ACT_END_C) &&
                  (v_cnt_r >= V_ACT_BEG_C) && (v_cnt_r < V_ACT_END_C);
        fs0_s   = (h_cnt_r == 11'd0) && (v_cnt_r == 11'd0);
        xpos0_s = 11'd0;
        ypos0_s = 11'd0;
        if (act0_s) begin
            xpos0_s = h_cnt_r - H_ACT_BEG_C;
            ypos0_s = v_cnt_r - V_ACT_BEG_C;
        end else begin
            xpos0_s = 11'd0;
            ypos0_s = 11'd0;
        end
    end

    // Stage 1: issue the coordinate request and start the flag pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_req   <= 1'b0;
            pixel_xpos <= 11'd0;
            pixel_ypos <= 11'd0;
            hs1_r      <= 1'b0;
            vs1_r      <= 1'b0;
            act1_r     <= 1'b0;
            fs1_r      <= 1'b0;
        end else begin
            data_req   <= act0_s;
            pixel_xpos <= xpos0_s;
            pixel_ypos <= ypos0_s;
            hs1_r      <= hs0_s;
            vs1_r      <= vs0_s;
            act1_r     <= act0_s;
            fs1_r      <= fs0_s;
        end
    end

    // Stage 2: hold flags while the renderer performs its lookup
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs2_r  <= 1'b0;
            vs2_r  <= 1'b0;
            act2_r <= 1'b0;
            fs2_r  <= 1'b0;
        end else begin
            hs2_r  <= hs1_r;
            vs2_r  <= vs1_r;
            act2_r <= act1_r;
            fs2_r  <= fs1_r;
        end
    end

    // Stage 3: panel pins; colour is blanked outside the active window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_hs      <= 1'b1;
            lcd_vs      <= 1'b1;
            lcd_de      <= 1'b0;
            lcd_rgb     <= 24'h0;
            frame_start <= 1'b0;
        end else begin
            lcd_hs      <= ~hs2_r;
            lcd_vs      <= ~vs2_r;
            lcd_de      <= act2_r;
            lcd_rgb     <= act2_r ? pixel_data : 24'h0;
            frame_start <= fs2_r;
        end
    end

    // Backlight comes on at the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_bl <= 1'b0;
        end else begin
            lcd_bl <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen with a reduced raster so full frames fit in a
// short run. A reference model derives every expected output from the number
// of clock edges since reset release; a renderer model answers requests with
// randomized colour and queues the expected panel colour for the monitor.
module tb_lcd_timing_gen;

    localparam int HS = 5;
    localparam int HB = 3;
    localparam int HD = 12;
    localparam int HF = 2;
    localparam int VS = 3;
    localparam int VB = 2;
    localparam int VD = 5;
    localparam int VF = 2;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int FR = HT * VT;
    localparam int HA = HS + HB;
    localparam int VA = VS + VB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pixel_data;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        data_req;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [23:0] lcd_rgb;
    logic        lcd_bl;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int k;
    int cnt_req, cnt_de, cnt_hs, cnt_vs, cnt_fs;
    int de_run = 0;
    logic [23:0] exp_q[$];
    logic [23:0] pend_val;
    bit          pend_valid = 1'b0;

    lcd_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pixel_data(pixel_data),
        .pixel_xpos(pixel_xpos),
        .pixel_ypos(pixel_ypos),
        .data_req(data_req),
        .lcd_hs(lcd_hs),
        .lcd_vs(lcd_vs),
        .lcd_de(lcd_de),
        .lcd_rgb(lcd_rgb),
        .lcd_bl(lcd_bl),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Edges since reset release: the raster position the counters hold now
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // Reference model: raster position p (edges since release) to panel state
    function automatic bit m_act(input int p);
        int q, h, v;
        if (p < 0) return 1'b0;
        q = p % FR;
        h = q % HT;
        v = q / HT;
        return (h >= HA) && (h < HA + HD) && (v >= VA) && (v < VA + VD);
    endfunction

    function automatic int m_x(input int p);
        if (!m_act(p)) return 0;
        return (p % FR) % HT - HA;
    endfunction

    function automatic int m_y(input int p);
        if (!m_act(p)) return 0;
        return (p % FR) / HT - VA;
    endfunction

    function automatic bit m_hs_low(input int p);
        if (p < 0) return 1'b0;
        return ((p % FR) % HT) < HS;
    endfunction

    function automatic bit m_vs_low(input int p);
        if (p < 0) return 1'b0;
        return ((p % FR) / HT) < VS;
    endfunction

    function automatic bit m_fs(input int p);
        if (p < 0) return 1'b0;
        return (p % FR) == 0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data_req"},    32'(data_req),    32'd0);
        check({tag, "_xpos"},        32'(pixel_xpos),  32'd0);
        check({tag, "_ypos"},        32'(pixel_ypos),  32'd0);
        check({tag, "_lcd_hs"},      32'(lcd_hs),      32'd1);
        check({tag, "_lcd_vs"},      32'(lcd_vs),      32'd1);
        check({tag, "_lcd_de"},      32'(lcd_de),      32'd0);
        check({tag, "_lcd_rgb"},     32'(lcd_rgb),     32'd0);
        check({tag, "_lcd_bl"},      32'(lcd_bl),      32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    // Renderer model: answer each request one cycle later, queue expectation
    initial begin : renderer
        logic [7:0] r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_valid = 1'b0;
                pixel_data = 24'h0;
            end else begin
                if (pend_valid) pixel_data = pend_val;
                else            pixel_data = 24'($urandom);
                pend_valid = 1'b0;
                r = 8'($urandom_range(255));
                if (data_req) begin
                    pend_val   = {pixel_ypos[7:0], pixel_xpos[7:0], r};
                    pend_valid = 1'b1;
                end
                if (m_act(k - 1))
                    exp_q.push_back({8'(m_y(k - 1)), 8'(m_x(k - 1)), r});
            end
        end
    end

    // Monitor: compare every output against the model each cycle
    initial begin : monitor
        logic [23:0] exp_rgb;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check_reset_values("rst");
                de_run = 0;
            end else begin
                check("data_req",    32'(data_req),    32'(m_act(k - 1)));
                check("pixel_xpos",  32'(pixel_xpos),  32'(m_x(k - 1)));
                check("pixel_ypos",  32'(pixel_ypos),  32'(m_y(k - 1)));
                check("lcd_hs",      32'(lcd_hs),      32'(!m_hs_low(k - 3)));
                check("lcd_vs",      32'(lcd_vs),      32'(!m_vs_low(k - 3)));
                check("lcd_de",      32'(lcd_de),      32'(m_act(k - 3)));
                check("frame_start", 32'(frame_start), 32'(m_fs(k - 3)));
                check("lcd_bl",      32'(lcd_bl),      32'(k >= 1));
                if (lcd_de) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL lcd_rgb at k=%0d: got %0h, expected none queued", k, lcd_rgb);
                    end else begin
                        exp_rgb = exp_q.pop_front();
                        check("lcd_rgb", 32'(lcd_rgb), 32'(exp_rgb));
                    end
                    de_run++;
                end else begin
                    check("lcd_rgb_blank", 32'(lcd_rgb), 32'd0);
                    if (de_run > 0) begin
                        check("de_run_length", 32'(de_run), 32'(HD));
                        de_run = 0;
                    end
                end
                cnt_req += int'(data_req);
                cnt_de  += int'(lcd_de);
                cnt_hs  += int'(!lcd_hs);
                cnt_vs  += int'(!lcd_vs);
                cnt_fs  += int'(frame_start);
            end
        end
    end

    // Wait until the raster reaches a given edge count, with a cycle budget
    task automatic wait_k(input int target);
        for (int i = 0; i < 4 * FR; i++) begin
            @(negedge clk);
            if (k >= target) break;
        end
        #1;
        if (k < target) check("wait_timeout", 32'(k), 32'(target));
    endtask

    // Main sequence: reset, run into frame 2, reset mid-frame, run 2 frames
    initial begin : main
        rst_n      = 1'b0;
        pixel_data = 24'h0;
        cnt_req = 0; cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Counters at line 8, pixel 12 of the second frame: mid active line
        wait_k(FR + 8 * HT + 12);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_values("async");

        cnt_req = 0; cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Two full frames seen on the panel pins
        wait_k(2 * FR + 2);
        check("count_data_req",    32'(cnt_req), 32'(2 * HD * VD));
        check("count_lcd_de",      32'(cnt_de),  32'(2 * HD * VD));
        check("count_hs_low",      32'(cnt_hs),  32'(2 * VT * HS));
        check("count_vs_low",      32'(cnt_vs),  32'(2 * VS * HT));
        check("count_frame_start", 32'(cnt_fs),  32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
